// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions.
// Contents:
//   XLEN           default address/data width
//   NOP_INST       addi x0,x0,0, presented to ID whenever no usable instruction exists
//   redirect_sel_e encoded winner of the redirect priority chain
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    RD_NONE = 3'd0,
    RD_TRAP = 3'd1,
    RD_ERET = 3'd2,
    RD_RST  = 3'd3,
    RD_ALU  = 3'd4,
    RD_JMP  = 3'd5
  } redirect_sel_e;

endpackage

// File: rtl/ifu_fifo.sv
// Small synchronous FIFO used by the fetch unit, both for the response buffer
// {inst, err, pc} and for the PC tags of in-flight requests.
// Ports:
//   i_clk, i_rstn   clock, async active-low reset
//   i_flush         empty the FIFO (wins over push/pop)
//   i_push, i_wdata write one entry (accepted when not full, or when popping)
//   i_pop           drop the head entry (ignored when empty)
//   o_rdata         head entry
//   o_count         current occupancy
module ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rstn,
  input  logic                           i_flush,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdata,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & (r_cnt != {CW{1'b0}});
  assign w_do_push = i_push & ((r_cnt != CW'(DEPTH)) | w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_wp  <= {PW{1'b0}};
      r_rp  <= {PW{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else if (i_flush) begin
      r_wp  <= {PW{1'b0}};
      r_rp  <= {PW{1'b0}};
      r_cnt <= {CW{1'b0}};
    end else begin
      if (w_do_push) begin
        r_wp <= next_ptr(r_wp);
      end else begin
        r_wp <= r_wp;
      end
      if (w_do_pop) begin
        r_rp <= next_ptr(r_rp);
      end else begin
        r_rp <= r_rp;
      end
      r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Entry storage.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {WIDTH{1'b0}};
      end
    end else if (w_do_push && !i_flush) begin
      r_mem[r_wp] <= i_wdata;
    end else begin
      r_mem[r_wp] <= r_mem[r_wp];
    end
  end

  assign o_rdata = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/ifu_sva.sv
// Protocol checker for the fetch unit's instruction-memory port.
// Ports:
//   i_clk, i_rstn  clock, async active-low reset
//   i_rvalid       memory response valid
//   i_infl_cnt     number of granted requests not yet answered
module ifu_sva #(
  parameter int CW = 1
) (
  input logic          i_clk,
  input logic          i_rstn,
  input logic          i_rvalid,
  input logic [CW-1:0] i_infl_cnt
);

  // A response with nothing in flight means the memory broke the protocol.
  a_rvalid_needs_request: assert property (
    @(posedge i_clk) disable iff (!i_rstn)
    i_rvalid |-> (i_infl_cnt != {CW{1'b0}})
  );

endmodule

// File: rtl/ifu.sv
// Instruction fetch stage. Owns the PC, issues word-aligned requests on the
// instruction-memory port and presents {pc, inst, valid, fault} to ID under
// control of the hazard unit's if_stall / if_flush.
// Build option: define IFU_FETCH_BUF_EN for a 2-entry response buffer (two
// requests in flight, 1 IPC at 1-cycle memory latency). Without it a single
// skid entry catches the response returned under stall and only one request
// is in flight.
// Ports:
//   i_clk, i_rstn                 clock, async active-low reset
//   i_if_stall, i_if_flush        hold / invalidate the ID-facing register
//   i_trap_en/i_trap_vec          redirect, highest priority
//   i_eret_en/i_eret_pc           redirect
//   i_restart_en/i_restart_pc     redirect
//   i_pc_alu_en/i_pc_alu          redirect
//   i_pc_jump_en/i_pc_jump        redirect, lowest priority
//   o_imem_req/o_imem_addr        fetch request, handshake with i_imem_gnt
//   i_imem_rvalid/rdata/err       in-order responses
//   o_id_pc/inst/valid/fault      registered output towards ID
module ifu #(
  parameter int              XLEN      = cpu_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = {XLEN{1'b0}}
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_if_stall,
  input  logic            i_if_flush,
  input  logic            i_trap_en,
  input  logic [XLEN-1:0] i_trap_vec,
  input  logic            i_eret_en,
  input  logic [XLEN-1:0] i_eret_pc,
  input  logic            i_restart_en,
  input  logic [XLEN-1:0] i_restart_pc,
  input  logic            i_pc_alu_en,
  input  logic [XLEN-1:0] i_pc_alu,
  input  logic            i_pc_jump_en,
  input  logic [XLEN-1:0] i_pc_jump,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic            i_imem_gnt,
  input  logic            i_imem_rvalid,
  input  logic [31:0]     i_imem_rdata,
  input  logic            i_imem_err,
  output logic [XLEN-1:0] o_id_pc,
  output logic [31:0]     o_id_inst,
  output logic            o_id_valid,
  output logic            o_id_fault
);

  import cpu_pkg::*;

`ifdef IFU_FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = 32 + 1 + XLEN;

  logic                r_run;
  logic [XLEN-1:0]     r_pc;
  logic [1:0]          r_kill_cnt;
  logic                r_id_valid;
  logic                r_id_fault;
  logic [31:0]         r_id_inst;
  logic [XLEN-1:0]     r_id_pc;

  redirect_sel_e       w_redir_sel;
  logic [XLEN-1:0]     w_redir_tgt;
  logic                w_redir;
  logic                w_kill_any;
  logic [XLEN-1:0]     w_fetch_pc;
  logic [2:0]          w_occupancy;
  logic                w_req;
  logic                w_hs;
  logic [CW-1:0]       w_infl_cnt;
  logic [XLEN-1:0]     w_rsp_pc;
  logic                w_rsp_ok;
  logic [CW-1:0]       w_buf_cnt;
  logic                w_buf_empty;
  logic                w_buf_push;
  logic                w_buf_pop;
  logic [EW-1:0]       w_buf_wdata;
  logic [EW-1:0]       w_buf_rdata;
  logic [EW-1:0]       w_ld_entry;
  logic                w_ld_valid;
  logic [31:0]         w_ld_inst;
  logic                w_ld_err;
  logic [XLEN-1:0]     w_ld_pc;

  // Redirect priority chain: trap > eret > restart > alu > jump.
  always_comb begin
    w_redir_sel = RD_NONE;
    if (i_trap_en) begin
      w_redir_sel = RD_TRAP;
    end else if (i_eret_en) begin
      w_redir_sel = RD_ERET;
    end else if (i_restart_en) begin
      w_redir_sel = RD_RST;
    end else if (i_pc_alu_en) begin
      w_redir_sel = RD_ALU;
    end else if (i_pc_jump_en) begin
      w_redir_sel = RD_JMP;
    end else begin
      w_redir_sel = RD_NONE;
    end
  end

  // Target of the winning redirect source.
  always_comb begin
    w_redir_tgt = r_pc;
    case (w_redir_sel)
      RD_TRAP: w_redir_tgt = i_trap_vec;
      RD_ERET: w_redir_tgt = i_eret_pc;
      RD_RST:  w_redir_tgt = i_restart_pc;
      RD_ALU:  w_redir_tgt = i_pc_alu;
      RD_JMP:  w_redir_tgt = i_pc_jump;
      default: w_redir_tgt = r_pc;
    endcase
  end

  assign w_redir    = (w_redir_sel != RD_NONE);
  assign w_kill_any = w_redir | i_if_flush;

  // The redirect target bypasses r_pc so the request in this very cycle
  // (granted or not) already points into the new stream.
  assign w_fetch_pc = w_redir_tgt & {{(XLEN-2){1'b1}}, 2'b00};

  // Killed responses still occupy a slot until they return, so they count here.
  assign w_occupancy = 3'(w_infl_cnt) + 3'(w_buf_cnt);
  assign w_req       = r_run & (w_occupancy < 3'(DEPTH));
  assign w_hs        = w_req & i_imem_gnt;

  assign o_imem_req  = w_req;
  assign o_imem_addr = w_fetch_pc;

  // PC tags of granted requests; responses come back in order.
  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (XLEN)
  ) u_tag_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (1'b0),
    .i_push  (w_hs),
    .i_wdata (w_fetch_pc),
    .i_pop   (i_imem_rvalid),
    .o_rdata (w_rsp_pc),
    .o_count (w_infl_cnt)
  );

  // A response arriving together with a redirect/flush is old-stream data too.
  assign w_rsp_ok = i_imem_rvalid & (r_kill_cnt == 2'd0) & ~w_kill_any;

  // Responses queue behind older buffered words to keep program order.
  assign w_buf_push  = w_rsp_ok & (i_if_stall | ~w_buf_empty);
  assign w_buf_pop   = ~i_if_stall & ~w_buf_empty & ~i_if_flush;
  assign w_buf_wdata = {i_imem_rdata, i_imem_err, w_rsp_pc};
  assign w_buf_empty = (w_buf_cnt == {CW{1'b0}});

  ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (i_if_flush),
    .i_push  (w_buf_push),
    .i_wdata (w_buf_wdata),
    .i_pop   (w_buf_pop),
    .o_rdata (w_buf_rdata),
    .o_count (w_buf_cnt)
  );

  assign w_ld_entry = w_buf_empty ? w_buf_wdata : w_buf_rdata;
  assign w_ld_valid = ~w_buf_empty | w_rsp_ok;
  assign {w_ld_inst, w_ld_err, w_ld_pc} = w_ld_entry;

  // Fetch enable rises on the first clock after reset release.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // Program counter: advance on handshake, otherwise park on a redirect target.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_pc <= RESET_VEC;
    end else if (w_hs) begin
      r_pc <= w_fetch_pc + XLEN'(32'd4);
    end else if (w_redir) begin
      r_pc <= w_fetch_pc;
    end else begin
      r_pc <= r_pc;
    end
  end

  // Count of old-stream responses still to be discarded.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_kill_cnt <= 2'd0;
    end else if (w_kill_any) begin
      // A grant in this cycle is not yet in w_infl_cnt, so it stays alive.
      if (i_imem_rvalid && (w_infl_cnt != {CW{1'b0}})) begin
        r_kill_cnt <= 2'(w_infl_cnt) - 2'd1;
      end else begin
        r_kill_cnt <= 2'(w_infl_cnt);
      end
    end else if (i_imem_rvalid && (r_kill_cnt != 2'd0)) begin
      r_kill_cnt <= r_kill_cnt - 2'd1;
    end else begin
      r_kill_cnt <= r_kill_cnt;
    end
  end

  // ID-facing register: flush beats stall beats load.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_id_valid <= 1'b0;
      r_id_fault <= 1'b0;
      r_id_inst  <= NOP_INST;
      r_id_pc    <= {XLEN{1'b0}};
    end else if (i_if_flush) begin
      r_id_valid <= 1'b0;
      r_id_fault <= 1'b0;
      r_id_inst  <= NOP_INST;
      r_id_pc    <= r_id_pc;
    end else if (!i_if_stall) begin
      if (w_ld_valid) begin
        r_id_valid <= 1'b1;
        r_id_fault <= w_ld_err;
        r_id_inst  <= w_ld_err ? NOP_INST : w_ld_inst;
        r_id_pc    <= w_ld_pc;
      end else begin
        r_id_valid <= 1'b0;
        r_id_fault <= 1'b0;
        r_id_inst  <= NOP_INST;
        r_id_pc    <= r_id_pc;
      end
    end else begin
      r_id_valid <= r_id_valid;
      r_id_fault <= r_id_fault;
      r_id_inst  <= r_id_inst;
      r_id_pc    <= r_id_pc;
    end
  end

  assign o_id_valid = r_id_valid;
  assign o_id_fault = r_id_fault;
  assign o_id_inst  = r_id_inst;
  assign o_id_pc    = r_id_pc;

  ifu_sva #(
    .CW (CW)
  ) u_sva (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_rvalid   (i_imem_rvalid),
    .i_infl_cnt (w_infl_cnt)
  );

endmodule

// File: tb/tb_ifu.sv
`timescale 1ns/1ps
module tb_ifu;
  import cpu_pkg::*;

`ifdef IFU_FETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        if_stall = 1'b0, if_flush = 1'b0;
  logic        trap_en = 1'b0, eret_en = 1'b0, restart_en = 1'b0, alu_en = 1'b0, jump_en = 1'b0;
  logic [31:0] trap_vec = 32'h0, eret_pc = 32'h0, restart_pc = 32'h0, pc_alu = 32'h0, pc_jump = 32'h0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0, imem_err = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'h0;
  logic [31:0] id_pc, id_inst;
  logic        id_valid, id_fault;

  ifu dut (
    .i_clk(clk), .i_rstn(rstn), .i_if_stall(if_stall), .i_if_flush(if_flush),
    .i_trap_en(trap_en), .i_trap_vec(trap_vec), .i_eret_en(eret_en), .i_eret_pc(eret_pc),
    .i_restart_en(restart_en), .i_restart_pc(restart_pc), .i_pc_alu_en(alu_en), .i_pc_alu(pc_alu),
    .i_pc_jump_en(jump_en), .i_pc_jump(pc_jump), .o_imem_req(imem_req), .o_imem_addr(imem_addr),
    .i_imem_gnt(imem_gnt), .i_imem_rvalid(imem_rvalid), .i_imem_rdata(imem_rdata), .i_imem_err(imem_err),
    .o_id_pc(id_pc), .o_id_inst(id_inst), .o_id_valid(id_valid), .o_id_fault(id_fault)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] addr; int due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic fault; } exp_t;
  pend_t pend_q[$];
  exp_t  exp_q[$];

  int          budget   = 0;
  int          latency  = 1;
  int          grants   = 0;
  int          cyc      = 0;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0003;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic fault);
    exp_t e;
    e.pc    = pc;
    e.fault = fault;
    e.inst  = fault ? NOP_INST : mem_word(pc);
    exp_q.push_back(e);
  endtask

  // Memory model: grants while budget lasts, answers in order after 'latency' cycles.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      #1;
      if (!rstn) begin
        pend_q.delete();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
      end else begin
        imem_gnt    = (budget > 0);
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = 32'h0;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_q[0].addr);
          imem_err    = err_en && (pend_q[0].addr == err_addr);
          void'(pend_q.pop_front());
        end
        #1;
        if (imem_req && imem_gnt) begin
          pend_q.push_back('{imem_addr, cyc + latency});
          budget--;
          grants++;
        end
      end
    end
  end

  // Scoreboard monitor: every instruction ID takes must match the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rstn && id_valid && !if_stall) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_inst: got pc=%0h inst=%0h expected none", id_pc, id_inst);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("id_entry{pc,inst,fault}", {31'h0, id_pc, id_inst, id_fault}, {31'h0, e.pc, e.inst, e.fault});
        end
      end else if (rstn && !id_valid) begin
        chk("nop_when_invalid", id_inst, NOP_INST);
      end
    end
  end

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while ((budget != 0 || pend_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_timeout"}, (n >= 200) ? 1 : 0, 0);
    chk({tag, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic wait_grants(input int target, input string tag);
    int n;
    n = 0;
    while (grants < target && n < 100) begin
      @(negedge clk);
      #3;
      n++;
    end
    chk({tag, "_grant_timeout"}, (n >= 100) ? 1 : 0, 0);
  endtask

  initial begin
    logic [31:0] snap_pc, snap_inst;
    logic        snap_v, snap_f;
    int          g0;
    int          n;

    // Reset state
    repeat (3) @(negedge clk);
    #3;
    chk("reset_req", imem_req, 1'b0);
    chk("reset_valid_fault", {id_valid, id_fault}, 2'b00);
    chk("reset_inst", id_inst, NOP_INST);
    chk("reset_id_pc", id_pc, 32'h0);
    chk("reset_addr", imem_addr, 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    #3;
    chk("req_after_reset", {imem_req, imem_addr}, {1'b1, 32'h0});

    // T1: sequential stream from the reset vector
    for (int i = 0; i < 6; i++) push_exp(32'h0 + 32'(4 * i), 1'b0);
    budget = 6;
    wait_done("t1");

    // T2: alu and jump redirect together while 0x18 is in flight
    latency = 3;
    g0 = grants;
    budget = 1;
    wait_grants(g0 + 1, "t2");
    @(negedge clk);
    alu_en = 1'b1; pc_alu = 32'h100; jump_en = 1'b1; pc_jump = 32'h200;
    latency = 1;
    budget = 2;
    push_exp(32'h100, 1'b0);
    push_exp(32'h104, 1'b0);
    #2;
    chk("t2_redirect_addr", imem_addr, 32'h100);
    @(negedge clk);
    alu_en = 1'b0; jump_en = 1'b0;
    wait_done("t2");

    // T3: stall for three cycles in the middle of a stream
    for (int i = 0; i < 6; i++) push_exp(32'h108 + 32'(4 * i), 1'b0);
    budget = 6;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (id_valid) break;
    end
    if_stall = 1'b1;
    #3;
    chk("t3_valid_at_stall", id_valid, 1'b1);
    snap_pc = id_pc; snap_inst = id_inst; snap_v = id_valid; snap_f = id_fault;
    repeat (2) begin
      @(negedge clk);
      #3;
      chk("t3_hold", {id_pc, id_inst, id_valid, id_fault}, {snap_pc, snap_inst, snap_v, snap_f});
    end
    @(negedge clk);
    if_stall = 1'b0;
    wait_done("t3");

    // T4: restart to 0, access fault at 0x8, then trap (eret also raised) to 0x83
    err_en = 1'b1; err_addr = 32'h8;
    restart_en = 1'b1; restart_pc = 32'h0;
    budget = 4;
    push_exp(32'h0, 1'b0);
    push_exp(32'h4, 1'b0);
    push_exp(32'h8, 1'b1);
    push_exp(32'hC, 1'b0);
    @(negedge clk);
    restart_en = 1'b0;
    wait_done("t4a");
    err_en = 1'b0;
    trap_en = 1'b1; trap_vec = 32'h83; eret_en = 1'b1; eret_pc = 32'h44;
    budget = 2;
    push_exp(32'h80, 1'b0);
    push_exp(32'h84, 1'b0);
    #2;
    chk("t4_trap_addr", imem_addr, 32'h80);
    @(negedge clk);
    trap_en = 1'b0; eret_en = 1'b0;
    wait_done("t4b");

    // T5: no grant for 4 cycles, then eret (alu also raised) retargets the pending request
    repeat (4) begin
      @(negedge clk);
      #2;
      chk("t5_req_held", {imem_req, imem_addr}, {1'b1, 32'h88});
    end
    @(negedge clk);
    eret_en = 1'b1; eret_pc = 32'h44; alu_en = 1'b1; pc_alu = 32'h300;
    budget = 2;
    push_exp(32'h44, 1'b0);
    push_exp(32'h48, 1'b0);
    #2;
    chk("t5_eret_addr", {imem_req, imem_addr}, {1'b1, 32'h44});
    @(negedge clk);
    eret_en = 1'b0; alu_en = 1'b0;
    wait_done("t5");

    // T6: flush and stall together with every slot in flight
    if_stall = 1'b1;
    latency = 3;
    g0 = grants;
    budget = DEPTH;
    wait_grants(g0 + DEPTH, "t6");
    @(negedge clk);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0; if_stall = 1'b0;
    #3;
    chk("t6_flushed_out", {id_valid, id_fault, id_inst}, {1'b0, 1'b0, NOP_INST});
    wait_done("t6a");
    latency = 1;
    restart_en = 1'b1; restart_pc = 32'h200;
    budget = 1;
    push_exp(32'h200, 1'b0);
    @(negedge clk);
    restart_en = 1'b0;
    wait_done("t6b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
